// File: rtl/rr_arb_idx8_pkg.sv
// Shared types and constants for the 8-requester round-robin arbiter.
package rr_arb_pkg;

    localparam int IDX_W = 3;
    localparam int N_REQ = 1 << IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

    // Index arithmetic wraps naturally at IDX_W bits (mod N_REQ).
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/rr_arb_idx8_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
interface rr_arb_idx8_if
    import rr_arb_pkg::*;
();

    logic [N_REQ-1:0] req;
    logic             done;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_en;
    logic             busy;

    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt_en,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt_en,
        output busy
    );

endinterface

// File: rtl/rr_arb_idx8_pick.sv
// Combinational rotating priority encoder: the first set request after ptr wins.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] win_idx_s;

    // Scan lowest priority first so the final overwrite is ptr+1, the highest.
    always_comb begin
        win_idx_s = 3'd0;
        idx_s     = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_s     = idx_add(ptr, IDX_W'(i + 1));
            win_idx_s = req[idx_s] ? idx_s : win_idx_s;
        end
    end

    assign win_idx = win_idx_s;
    assign win_vld = |req;

endmodule

// File: rtl/rr_arb_idx8.sv
// Round-robin arbiter with binary-index grant and a mandatory idle bubble.
// Optional grant timeout enabled by macro RR_ARB_TIMEOUT_EN.
module rr_arb_idx8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_idx8_if.slave bus
);

    state_e           state_d, state_q;
    logic [IDX_W-1:0] ptr_d, ptr_q;
    logic [IDX_W-1:0] gnt_idx_d, gnt_idx_q;
    logic             gnt_en_d, gnt_en_q;
    logic [IDX_W-1:0] win_idx_s;
    logic             win_vld_s;
    logic             release_s;
    logic             timeout_s;

    rr_pick u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_idx (win_idx_s),
        .win_vld (win_vld_s)
    );

    assign release_s = bus.done | ~bus.req[gnt_idx_q] | timeout_s;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int               HC_W     = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0]  HC_MAX   = {HC_W{1'b1}};
    localparam logic [HC_W-1:0]  HOLD_LIM = HC_W'(MAX_HOLD);

    logic [HC_W-1:0] hold_cnt_d, hold_cnt_q;

    assign timeout_s = (state_q == GRANT) && (hold_cnt_q == HOLD_LIM);

    // Grant-length counter: starts at 1 on grant, cleared on release.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld_s) begin
                    hold_cnt_d = HC_W'(1);
                end else begin
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HC_MAX) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: hold_cnt_d = '0;
        endcase
    end

    // Grant-length counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, hold in GRANT until release.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_en_d  = gnt_en_q;
        case (state_q)
            IDLE: begin
                if (win_vld_s) begin
                    state_d   = GRANT;
                    gnt_idx_d = win_idx_s;
                    gnt_en_d  = 1'b1;
                end else begin
                    gnt_en_d  = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_d  = IDLE;
                    ptr_d    = gnt_idx_q;
                    gnt_en_d = 1'b0;
                end else begin
                    gnt_en_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_en_d = 1'b0;
            end
        endcase
    end

    // FSM, pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RST;
            gnt_idx_q <= 3'd0;
            gnt_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_en_q  <= gnt_en_d;
        end
    end

    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_en  = gnt_en_q;
    assign bus.busy    = gnt_en_q;

endmodule

// File: tb/tb_rr_arb_idx8.sv
// Directed bench for rr_arb_idx8; expected {busy,gnt_en,gnt_idx} go through a queue.
module tb_rr_arb_idx8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [4:0] exp_q[$];

    rr_arb_idx8_if bus ();

    rr_arb_idx8 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic en, input logic [2:0] idx);
        exp_q.push_back({en, en, idx});
    endtask

    task automatic check_out(input string tag);
        logic [4:0] exp_v;
        logic [4:0] obs_v;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {bus.busy, bus.gnt_en, bus.gnt_idx};
            checks++;
            assert (obs_v === exp_v) else begin
                failures++;
                $error("FAIL %s observed busy/en/idx=%b/%b/%0d expected %b/%b/%0d",
                       tag, obs_v[4], obs_v[3], obs_v[2:0], exp_v[4], exp_v[3], exp_v[2:0]);
            end
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge, compare.
    task automatic cyc(input string tag, input logic [7:0] r, input logic d,
                       input logic en, input logic [2:0] idx);
        bus.req  = r;
        bus.done = d;
        push_exp(en, idx);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        #1;
        push_exp(1'b0, 3'd0);
        check_out("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, release by done.
        cyc("t1_grant",   8'h01, 1'b0, 1'b1, 3'd0);
        cyc("t1_release", 8'h01, 1'b1, 1'b0, 3'd0);
        cyc("t1_idle",    8'h00, 1'b0, 1'b0, 3'd0);

        // Alternation 7,0,7 with exactly one bubble each.
        cyc("t2_g7a", 8'h81, 1'b0, 1'b1, 3'd7);
        cyc("t2_r7a", 8'h81, 1'b1, 1'b0, 3'd7);
        cyc("t2_g0",  8'h81, 1'b0, 1'b1, 3'd0);
        cyc("t2_r0",  8'h81, 1'b1, 1'b0, 3'd0);
        cyc("t2_g7b", 8'h81, 1'b0, 1'b1, 3'd7);
        cyc("t2_r7b", 8'h81, 1'b1, 1'b0, 3'd7);
        cyc("t2_hold_idx", 8'h00, 1'b0, 1'b0, 3'd7);

        // Owner 3; other reqs ignored; done and req[3] drop together.
        cyc("t3_g3",      8'h08, 1'b0, 1'b1, 3'd3);
        cyc("t3_others",  8'hFF, 1'b0, 1'b1, 3'd3);
        cyc("t3_release", 8'hF7, 1'b1, 1'b0, 3'd3);
        cyc("t3_next4",   8'hFF, 1'b0, 1'b1, 3'd4);
        cyc("t3_r4",      8'hFF, 1'b1, 1'b0, 3'd4);
        cyc("t3_idle",    8'h00, 1'b0, 1'b0, 3'd4);

        // ptr=6 with 0 and 6 requesting picks 0; then full rotation for 7.
        cyc("t4_g6",    8'h40, 1'b0, 1'b1, 3'd6);
        cyc("t4_r6",    8'h40, 1'b1, 1'b0, 3'd6);
        cyc("t4_wrap0", 8'h41, 1'b0, 1'b1, 3'd0);
        cyc("t4_drop0", 8'h40, 1'b0, 1'b0, 3'd0);
        cyc("t4_idle",  8'h00, 1'b0, 1'b0, 3'd0);
        cyc("t4_g7",    8'h80, 1'b0, 1'b1, 3'd7);
        cyc("t4_r7",    8'h80, 1'b1, 1'b0, 3'd7);
        cyc("t4_regr7", 8'h80, 1'b0, 1'b1, 3'd7);
        cyc("t4_drop7", 8'h00, 1'b0, 1'b0, 3'd7);
        cyc("idle_done_ignored", 8'h00, 1'b1, 1'b0, 3'd7);

`ifdef RR_ARB_TIMEOUT_EN
        // MAX_HOLD=4: four high cycles, one bubble, re-grant.
        cyc("to_g",   8'h04, 1'b0, 1'b1, 3'd2);
        for (int i = 0; i < 3; i++) begin
            cyc("to_hold", 8'h04, 1'b0, 1'b1, 3'd2);
        end
        cyc("to_release", 8'h04, 1'b0, 1'b0, 3'd2);
        cyc("to_regrant", 8'h04, 1'b0, 1'b1, 3'd2);
        cyc("to_drop",    8'h00, 1'b0, 1'b0, 3'd2);
`else
        // No timeout: grant persists well past MAX_HOLD.
        cyc("nto_g", 8'h04, 1'b0, 1'b1, 3'd2);
        for (int i = 0; i < 20; i++) begin
            cyc("nto_hold", 8'h04, 1'b0, 1'b1, 3'd2);
        end
        cyc("nto_drop", 8'h00, 1'b0, 1'b0, 3'd2);
`endif

        // Asynchronous reset mid-grant, then restart from index 0.
        cyc("rst_pre_g3", 8'hFF, 1'b0, 1'b1, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 3'd0);
        check_out("rst_async");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc("rst_first_g0", 8'hFF, 1'b0, 1'b1, 3'd0);
        cyc("rst_r0",       8'hFF, 1'b1, 1'b0, 3'd0);
        cyc("rst_next1",    8'hFF, 1'b0, 1'b1, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
